// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty control unit.
//  - state_t  : FSM state encoding (encodings 6 and 7 are unreachable)
//  - FMT_*    : instruction format codes held in d_in[1:0]
//  - *_lsb()  : instruction field offsets as functions of DATA_W / REG_AW
//  - MUX_IMM  : MSB value of mux_sel that selects the immediate operand
package bitty_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CALC  = 3'd3,
    ST_STORE = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] FMT_RR = 2'b00;
  localparam logic [1:0] FMT_RI = 2'b01;

  localparam int ALU_LSB = 2;
  localparam int FMT_LSB = 0;

  localparam logic MUX_IMM = 1'b1;

  // rx occupies the top REG_AW bits of the instruction
  function automatic int rx_lsb(input int data_w, input int reg_aw);
    return data_w - reg_aw;
  endfunction

  // ry sits directly below rx
  function automatic int ry_lsb(input int data_w, input int reg_aw);
    return data_w - 2 * reg_aw;
  endfunction

endpackage

// File: rtl/bitty_onehot_dec.sv
// One-hot decoder with enable.
//  en     in  1       decoder enable; all outputs 0 when low
//  idx    in  IN_W    binary index
//  onehot out OUT_W   onehot[idx] = en
module bitty_onehot_dec #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic             en,
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == IN_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/bitty_control_unit_p.sv
// Multi-cycle control FSM for the bitty datapath (FETCH/LOAD/CALC/STORE).
//  clk          in   clock, rising edge
//  reset        in   synchronous, active-high; also forces all outputs to 0
//  run          in   start/continue execution (sampled in IDLE, STORE, ERR)
//  d_in         in   instruction register contents
//  done         out  one-cycle pulse at STORE or ERR
//  busy         out  high in every non-IDLE state
//  illegal      out  one-cycle pulse in ERR
//  en_i/en_s/en_c   out  load IR / ALU source / ALU result
//  en_reg       out  one-hot register-file write enable
//  alu_sel      out  ALU operation
//  mux_sel      out  operand mux; MSB=1 selects immediate, else {0,reg idx}
//  instr_count  out  legal instructions retired (wraps)
module bitty_control_unit_p
  import bitty_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NUM_REGS  = 8,
  parameter  int ALU_SEL_W = 3,
  parameter  int CNT_W     = 16,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DATA_W-1:0]    d_in,
  output logic                 done,
  output logic                 busy,
  output logic                 illegal,
  output logic                 en_i,
  output logic                 en_s,
  output logic                 en_c,
  output logic [NUM_REGS-1:0]  en_reg,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic [REG_AW:0]      mux_sel,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int RX_LSB = rx_lsb(DATA_W, REG_AW);
  localparam int RY_LSB = ry_lsb(DATA_W, REG_AW);

  // Live instruction fields
  logic [REG_AW-1:0]    rx_in;
  logic [REG_AW-1:0]    ry_in;
  logic [ALU_SEL_W-1:0] alu_in;
  logic [1:0]           fmt_in;

  assign rx_in  = d_in[RX_LSB +: REG_AW];
  assign ry_in  = d_in[RY_LSB +: REG_AW];
  assign alu_in = d_in[ALU_LSB +: ALU_SEL_W];
  assign fmt_in = d_in[FMT_LSB +: 2];

  // Bits between the register fields and the ALU field carry no meaning
  logic unused_d_in;
  assign unused_d_in = ^d_in;

  state_t               state_reg, state_next;
  logic [REG_AW-1:0]    rx_reg, ry_reg;
  logic [ALU_SEL_W-1:0] alu_reg;
  logic [1:0]           fmt_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 store_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      rx_reg    <= '0;
      ry_reg    <= '0;
      alu_reg   <= '0;
      fmt_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Fields are captured in LOAD regardless of format; ERR ignores them
      if (state_reg == ST_LOAD) begin
        rx_reg  <= rx_in;
        ry_reg  <= ry_in;
        alu_reg <= alu_in;
        fmt_reg <= fmt_in;
      end
      if (state_reg == ST_STORE) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    busy       = 1'b1;
    illegal    = 1'b0;
    en_i       = 1'b0;
    en_s       = 1'b0;
    en_c       = 1'b0;
    alu_sel    = '0;
    mux_sel    = '0;
    store_en   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        en_i       = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // Format bit 1 set means illegal; decode straight from the IR
        if (!fmt_in[1]) begin
          mux_sel    = {1'b0, rx_in};
          en_s       = 1'b1;
          state_next = ST_CALC;
        end else begin
          state_next = ST_ERR;
        end
      end
      ST_CALC: begin
        en_c       = 1'b1;
        alu_sel    = alu_reg;
        mux_sel    = (fmt_reg == FMT_RI) ? {MUX_IMM, {REG_AW{1'b0}}}
                                         : {1'b0, ry_reg};
        state_next = ST_STORE;
      end
      ST_STORE: begin
        store_en   = 1'b1;
        done       = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_ERR: begin
        illegal    = 1'b1;
        done       = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase

    // Reset overrides everything in the same cycle it is asserted
    if (reset) begin
      done     = 1'b0;
      busy     = 1'b0;
      illegal  = 1'b0;
      en_i     = 1'b0;
      en_s     = 1'b0;
      en_c     = 1'b0;
      alu_sel  = '0;
      mux_sel  = '0;
      store_en = 1'b0;
    end
  end

  assign instr_count = reset ? '0 : count_reg;

  bitty_onehot_dec #(
    .IN_W  (REG_AW),
    .OUT_W (NUM_REGS)
  ) u_reg_dec (
    .en     (store_en),
    .idx    (rx_reg),
    .onehot (en_reg)
  );

endmodule

// File: tb/tb_bitty_control_unit_p.sv
module tb_bitty_control_unit_p;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] d_in;
  logic        done, busy, illegal, en_i, en_s, en_c;
  logic [7:0]  en_reg;
  logic [2:0]  alu_sel;
  logic [3:0]  mux_sel;
  logic [15:0] instr_count;

  // Small configuration: NUM_REGS=4, DATA_W=8, ALU_SEL_W=2
  logic        s_reset, s_run;
  logic [7:0]  s_d_in;
  logic        s_done, s_busy, s_illegal, s_en_i, s_en_s, s_en_c;
  logic [3:0]  s_en_reg;
  logic [1:0]  s_alu_sel;
  logic [2:0]  s_mux_sel;
  logic [15:0] s_instr_count;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  always #5 clk = ~clk;

  bitty_control_unit_p u_dut (
    .clk(clk), .reset(reset), .run(run), .d_in(d_in),
    .done(done), .busy(busy), .illegal(illegal),
    .en_i(en_i), .en_s(en_s), .en_c(en_c), .en_reg(en_reg),
    .alu_sel(alu_sel), .mux_sel(mux_sel), .instr_count(instr_count)
  );

  bitty_control_unit_p #(.DATA_W(8), .NUM_REGS(4), .ALU_SEL_W(2), .CNT_W(16)) u_dut_s (
    .clk(clk), .reset(s_reset), .run(s_run), .d_in(s_d_in),
    .done(s_done), .busy(s_busy), .illegal(s_illegal),
    .en_i(s_en_i), .en_s(s_en_s), .en_c(s_en_c), .en_reg(s_en_reg),
    .alu_sel(s_alu_sel), .mux_sel(s_mux_sel), .instr_count(s_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_busy, input logic e_en_i,
                          input logic e_en_s, input logic e_en_c, input logic [7:0] e_en_reg,
                          input logic [3:0] e_mux, input logic [2:0] e_alu,
                          input logic e_done, input logic e_ill);
    check({tag, ".busy"},    32'(busy),    32'(e_busy));
    check({tag, ".en_i"},    32'(en_i),    32'(e_en_i));
    check({tag, ".en_s"},    32'(en_s),    32'(e_en_s));
    check({tag, ".en_c"},    32'(en_c),    32'(e_en_c));
    check({tag, ".en_reg"},  32'(en_reg),  32'(e_en_reg));
    check({tag, ".mux_sel"}, 32'(mux_sel), 32'(e_mux));
    check({tag, ".alu_sel"}, 32'(alu_sel), 32'(e_alu));
    check({tag, ".done"},    32'(done),    32'(e_done));
    check({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  // Advance to just after the next rising edge (inputs change here)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge to sample outputs
  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; d_in = 16'h2408;
    s_reset = 1'b1; s_run = 1'b0; s_d_in = 8'h00;

    // Reset with run high: outputs forced low, reset wins
    mid();
    chk_outs("rst", 0, 0, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    check("rst.count", 32'(instr_count), 32'd0);
    cyc();
    reset = 1'b0;
    mid();
    check("rst_run.idle_busy", 32'(busy), 32'd0);
    check("rst_run.idle_en_i", 32'(en_i), 32'd0);

    // Test 1: reg-reg 16'h2408 (rx=1, ry=1, alu=2)
    cyc(); run = 1'b0;
    mid(); chk_outs("t1.fetch", 1, 1, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    cyc(); mid(); chk_outs("t1.load",  1, 0, 1, 0, 8'h00, 4'h1, 3'h0, 0, 0);
    cyc(); mid(); chk_outs("t1.calc",  1, 0, 0, 1, 8'h00, 4'h1, 3'h2, 0, 0);
    cyc(); mid(); chk_outs("t1.store", 1, 0, 0, 0, 8'h02, 4'h0, 3'h0, 1, 0);
    cyc(); mid(); chk_outs("t1.idle",  0, 0, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    check("t1.count", 32'(instr_count), 32'd1);
    $display("txn t1 reg-reg d_in=%h count=%0d", d_in, instr_count);

    // Test 2: reg-imm 16'hE005 (rx=7, alu=1, fmt=01)
    run = 1'b1; d_in = 16'hE005;
    cyc(); run = 1'b0;
    mid(); check("t2.fetch.en_i", 32'(en_i), 32'd1);
    cyc(); mid(); chk_outs("t2.load",  1, 0, 1, 0, 8'h00, 4'h7, 3'h0, 0, 0);
    cyc(); mid(); chk_outs("t2.calc",  1, 0, 0, 1, 8'h00, 4'h8, 3'h1, 0, 0);
    cyc(); mid(); chk_outs("t2.store", 1, 0, 0, 0, 8'h80, 4'h0, 3'h0, 1, 0);
    cyc(); mid(); check("t2.count", 32'(instr_count), 32'd2);
    $display("txn t2 reg-imm d_in=%h count=%0d", d_in, instr_count);

    // Test 3: illegal format 2'b11
    run = 1'b1; d_in = 16'h2403;
    cyc(); run = 1'b0;
    mid(); check("t3.fetch.en_i", 32'(en_i), 32'd1);
    cyc(); mid(); chk_outs("t3.load", 1, 0, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    cyc(); mid(); chk_outs("t3.err",  1, 0, 0, 0, 8'h00, 4'h0, 3'h0, 1, 1);
    cyc(); mid(); chk_outs("t3.idle", 0, 0, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    check("t3.count", 32'(instr_count), 32'd2);
    $display("txn t3 illegal d_in=%h count=%0d", d_in, instr_count);

    // Test 4: back-to-back with run held, from a fresh reset
    reset = 1'b1;
    cyc(); reset = 1'b0; run = 1'b1; d_in = 16'h2408;
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i == 12) run = 1'b0;
      mid();
      done_cnt += int'(done);
      if (i == 5 || i == 9) check($sformatf("t4.refetch%0d", i), 32'(en_i), 32'd1);
    end
    check("t4.done_pulses", 32'(done_cnt), 32'd3);
    cyc(); mid();
    check("t4.idle_busy", 32'(busy), 32'd0);
    check("t4.count", 32'(instr_count), 32'd3);
    $display("txn t4 back-to-back done=%0d count=%0d", done_cnt, instr_count);

    // Test 5: drop run in LOAD; instruction still completes
    run = 1'b1; d_in = 16'hE005;
    cyc();
    cyc(); run = 1'b0;
    mid(); check("t5.load.en_s", 32'(en_s), 32'd1);
    cyc(); mid(); check("t5.calc.en_c", 32'(en_c), 32'd1);
    cyc(); mid(); chk_outs("t5.store", 1, 0, 0, 0, 8'h80, 4'h0, 3'h0, 1, 0);
    cyc(); mid();
    check("t5.idle_busy", 32'(busy), 32'd0);
    check("t5.count", 32'(instr_count), 32'd4);
    $display("txn t5 run-drop count=%0d", instr_count);

    // Test 6: reset asserted in CALC discards the instruction
    run = 1'b1; d_in = 16'h2408;
    cyc(); run = 1'b0;
    cyc();
    cyc(); reset = 1'b1;
    mid(); chk_outs("t6.rst_calc", 0, 0, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    cyc(); reset = 1'b0;
    mid(); chk_outs("t6.idle", 0, 0, 0, 0, 8'h00, 4'h0, 3'h0, 0, 0);
    check("t6.count", 32'(instr_count), 32'd0);
    cyc(); mid(); check("t6.no_write", 32'(en_reg), 32'd0);
    $display("txn t6 reset-in-calc count=%0d", instr_count);

    // Small configuration rerun of test 1: 8'h58 (rx=1, ry=1, alu=2, fmt=00)
    s_reset = 1'b0; s_run = 1'b1; s_d_in = 8'h58;
    cyc(); s_run = 1'b0;
    mid(); check("s1.fetch.en_i", 32'(s_en_i), 32'd1);
    cyc(); mid();
    check("s1.load.en_s", 32'(s_en_s), 32'd1);
    check("s1.load.mux", 32'(s_mux_sel), 32'h1);
    cyc(); mid();
    check("s1.calc.en_c", 32'(s_en_c), 32'd1);
    check("s1.calc.mux", 32'(s_mux_sel), 32'h1);
    check("s1.calc.alu", 32'(s_alu_sel), 32'h2);
    cyc(); mid();
    check("s1.store.en_reg", 32'(s_en_reg), 32'h2);
    check("s1.store.done", 32'(s_done), 32'd1);
    cyc(); mid();
    check("s1.idle_busy", 32'(s_busy), 32'd0);
    check("s1.count", 32'(s_instr_count), 32'd1);
    $display("txn s1 small reg-reg d_in=%h count=%0d", s_d_in, s_instr_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
